// File: rtl/regfile_write_arbiter_if.sv
// Bus between the two writeback requesters and the register-file write port.
// The arbiter takes the slave side; the requesters and register file take the master side.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              REGWRITE;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] writeData;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  stall,
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready,
        output REGWRITE, write_reg, writeData,
        output conflict_cnt
    );

    modport master (
        output stall,
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready,
        input  REGWRITE, write_reg, writeData,
        input  conflict_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and
// load (B) writeback, with a registered write stage and a saturating contention counter.
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e              r_last_grant;
    logic                r_regwrite;
    logic [ADDR_W-1:0]   r_write_reg;
    logic [DATA_W-1:0]   r_write_data;
    logic [CNT_W-1:0]    r_conflict_cnt;

    logic                w_a_zero;
    logic                w_b_zero;
    logic                w_a_real;
    logic                w_b_real;
    logic                w_contend;
    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_grant_a;
    logic                w_grant_b;

    // Zero-register writes are absorbed: always accepted, never contend, never touch the port.
    assign w_a_zero  = (bus.a_reg == ZERO_IDX);
    assign w_b_zero  = (bus.b_reg == ZERO_IDX);
    assign w_a_real  = bus.a_valid && !w_a_zero;
    assign w_b_real  = bus.b_valid && !w_b_zero;
    assign w_contend = w_a_real && w_b_real;

    assign w_a_ready = !bus.stall && bus.a_valid &&
                       (w_a_zero || !w_b_real || (r_last_grant == GRANT_B));
    assign w_b_ready = !bus.stall && bus.b_valid &&
                       (w_b_zero || !w_a_real || (r_last_grant == GRANT_A));

    assign w_grant_a = w_a_ready && w_a_real;
    assign w_grant_b = w_b_ready && w_b_real;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant   <= GRANT_B;
            r_regwrite     <= 1'b0;
            r_write_reg    <= '0;
            r_write_data   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_regwrite <= w_grant_a || w_grant_b;

            if (w_grant_a) begin
                r_write_reg  <= bus.a_reg;
                r_write_data <= bus.a_data;
                r_last_grant <= GRANT_A;
            end else if (w_grant_b) begin
                r_write_reg  <= bus.b_reg;
                r_write_data <= bus.b_data;
                r_last_grant <= GRANT_B;
            end

            if (!bus.stall && w_contend && (r_conflict_cnt != CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign bus.a_ready      = w_a_ready;
    assign bus.b_ready      = w_b_ready;
    assign bus.REGWRITE     = r_regwrite;
    assign bus.write_reg    = r_write_reg;
    assign bus.writeData    = r_write_data;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; a second instance with a 2-bit counter
// shares the same stimulus to exercise counter saturation.
module tb_regfile_write_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(16)) bus ();
    regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(2))  bus_s ();

    regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CNT_W(2)) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    assign bus_s.stall   = bus.stall;
    assign bus_s.a_valid = bus.a_valid;
    assign bus_s.a_reg   = bus.a_reg;
    assign bus_s.a_data  = bus.a_data;
    assign bus_s.b_valid = bus.b_valid;
    assign bus_s.b_reg   = bus.b_reg;
    assign bus_s.b_data  = bus.b_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall   = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_reg   = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_reg   = '0;
        bus.b_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Contention sequence: both always valid, winner re-presents its next request.
    logic [4:0]  t3_reg  [4] = '{5'd10, 5'd20, 5'd11, 5'd21};
    logic [63:0] t3_data [4] = '{64'd100, 64'd200, 64'd101, 64'd201};

    initial begin
        int ia;
        int ib;
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_regwrite", 64'(bus.REGWRITE), 64'd0);
        check("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
        check("rst_write_reg", 64'(bus.write_reg), 64'd0);
        check("rst_writedata", bus.writeData, 64'd0);
        tick();
        rst_n = 1'b1;

        // 1: single A write
        bus.a_valid = 1'b1; bus.a_reg = 5'd2; bus.a_data = 64'd99999;
        #1;
        check("t1_a_ready", 64'(bus.a_ready), 64'd1);
        check("t1_b_ready", 64'(bus.b_ready), 64'd0);
        tick();
        check("t1_regwrite", 64'(bus.REGWRITE), 64'd1);
        check("t1_write_reg", 64'(bus.write_reg), 64'd2);
        check("t1_writedata", bus.writeData, 64'd99999);
        bus.a_valid = 1'b0;
        tick();
        check("t1_regwrite_off", 64'(bus.REGWRITE), 64'd0);
        check("t1_write_reg_hold", 64'(bus.write_reg), 64'd2);
        check("t1_writedata_hold", bus.writeData, 64'd99999);

        // 2: both valid, A wins first after reset, then B uncontended
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 5'd3; bus.a_data = 64'd11;
        bus.b_valid = 1'b1; bus.b_reg = 5'd4; bus.b_data = 64'd22;
        #1;
        check("t2_a_ready", 64'(bus.a_ready), 64'd1);
        check("t2_b_ready", 64'(bus.b_ready), 64'd0);
        tick();
        check("t2_w0_reg", 64'(bus.write_reg), 64'd3);
        check("t2_w0_data", bus.writeData, 64'd11);
        bus.a_valid = 1'b0;
        #1;
        check("t2_b_ready2", 64'(bus.b_ready), 64'd1);
        tick();
        check("t2_w1_regwrite", 64'(bus.REGWRITE), 64'd1);
        check("t2_w1_reg", 64'(bus.write_reg), 64'd4);
        check("t2_w1_data", bus.writeData, 64'd22);
        check("t2_cnt", 64'(bus.conflict_cnt), 64'd1);

        // 3: sustained contention alternates A,B,A,B
        do_reset();
        ia = 0;
        ib = 0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.a_reg = 5'(10 + ia); bus.a_data = 64'(100 + ia);
            bus.b_reg = 5'(20 + ib); bus.b_data = 64'(200 + ib);
            #1;
            check($sformatf("t3_a_ready%0d", k), 64'(bus.a_ready), 64'((k % 2) == 0));
            check($sformatf("t3_b_ready%0d", k), 64'(bus.b_ready), 64'((k % 2) == 1));
            if ((k % 2) == 0) ia++;
            else ib++;
            tick();
            check($sformatf("t3_regwrite%0d", k), 64'(bus.REGWRITE), 64'd1);
            check($sformatf("t3_reg%0d", k), 64'(bus.write_reg), 64'(t3_reg[k]));
            check($sformatf("t3_data%0d", k), bus.writeData, t3_data[k]);
        end
        check("t3_cnt", 64'(bus.conflict_cnt), 64'd4);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        check("t3_regwrite_off", 64'(bus.REGWRITE), 64'd0);

        // 4: zero-register writes absorbed without touching last_grant
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 5'd31; bus.a_data = 64'd5555;
        #1;
        check("t4_zero_alone_ready", 64'(bus.a_ready), 64'd1);
        tick();
        check("t4_zero_alone_regwrite", 64'(bus.REGWRITE), 64'd0);
        bus.a_reg = 5'd6; bus.a_data = 64'd66;
        bus.b_valid = 1'b1; bus.b_reg = 5'd7; bus.b_data = 64'd77;
        #1;
        check("t4_lastgrant_a_ready", 64'(bus.a_ready), 64'd1);
        check("t4_lastgrant_b_ready", 64'(bus.b_ready), 64'd0);
        bus.a_reg = 5'd31; bus.a_data = 64'd5555;
        bus.b_reg = 5'd5;  bus.b_data = 64'd7;
        #1;
        check("t4_zero_a_ready", 64'(bus.a_ready), 64'd1);
        check("t4_zero_b_ready", 64'(bus.b_ready), 64'd1);
        tick();
        check("t4_regwrite", 64'(bus.REGWRITE), 64'd1);
        check("t4_write_reg", 64'(bus.write_reg), 64'd5);
        check("t4_writedata", bus.writeData, 64'd7);
        check("t4_cnt", 64'(bus.conflict_cnt), 64'd0);
        bus.b_valid = 1'b0;
        tick();
        check("t4_zero_only_regwrite", 64'(bus.REGWRITE), 64'd0);
        check("t4_write_reg_hold", 64'(bus.write_reg), 64'd5);

        // 5: stall blocks grants and counting
        do_reset();
        bus.stall = 1'b1;
        bus.a_valid = 1'b1; bus.a_reg = 5'd2; bus.a_data = 64'd123;
        bus.b_valid = 1'b1; bus.b_reg = 5'd9; bus.b_data = 64'd456;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t5_stall_a_ready%0d", k), 64'(bus.a_ready), 64'd0);
            check($sformatf("t5_stall_b_ready%0d", k), 64'(bus.b_ready), 64'd0);
            tick();
            check($sformatf("t5_stall_regwrite%0d", k), 64'(bus.REGWRITE), 64'd0);
        end
        check("t5_stall_cnt", 64'(bus.conflict_cnt), 64'd0);
        bus.b_valid = 1'b0;
        bus.stall = 1'b0;
        #1;
        check("t5_a_ready", 64'(bus.a_ready), 64'd1);
        tick();
        check("t5_regwrite", 64'(bus.REGWRITE), 64'd1);
        check("t5_write_reg", 64'(bus.write_reg), 64'd2);
        check("t5_writedata", bus.writeData, 64'd123);
        bus.stall = 1'b1;
        tick();
        check("t5_stall_drop_regwrite", 64'(bus.REGWRITE), 64'd0);
        bus.stall = 1'b0;
        bus.a_valid = 1'b0;

        // 6: counter saturation and mid-transfer reset
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 5'd12; bus.a_data = 64'd1;
        bus.b_valid = 1'b1; bus.b_reg = 5'd13; bus.b_data = 64'd2;
        for (int k = 0; k < 5; k++) tick();
        check("t6_small_cnt_sat", 64'(bus_s.conflict_cnt), 64'd3);
        check("t6_main_cnt", 64'(bus.conflict_cnt), 64'd5);
        tick();
        check("t6_small_cnt_hold", 64'(bus_s.conflict_cnt), 64'd3);
        check("t6_regwrite_before_rst", 64'(bus.REGWRITE), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_regwrite", 64'(bus.REGWRITE), 64'd0);
        check("t6_rst_cnt", 64'(bus.conflict_cnt), 64'd0);
        check("t6_rst_small_cnt", 64'(bus_s.conflict_cnt), 64'd0);
        check("t6_rst_write_reg", 64'(bus.write_reg), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_rearb_a_ready", 64'(bus.a_ready), 64'd1);
        check("t6_rearb_b_ready", 64'(bus.b_ready), 64'd0);
        tick();
        check("t6_rearb_write_reg", 64'(bus.write_reg), 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (REGWRITE / write_reg / writeData) between two writeback requesters: A (ALU writeback) and B (memory-load writeback). Arbitration is round-robin with a one-cycle registered output stage. Writes to the zero register are absorbed without using the port. A saturating contention counter supports performance debug.

Parameters:
DATA_W, 64, width of write data
ADDR_W, 5, register index width
ZERO_REG, 31, index of the hardwired-zero register (writes discarded)
CNT_W, 16, width of contention counter

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  pipeline stall; blocks all grants while high
a_valid  input  1  requester A has a write pending
a_reg  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
a_ready  output  1  A request accepted this cycle
b_valid  input  1  requester B has a write pending
b_reg  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
b_ready  output  1  B request accepted this cycle
REGWRITE  output  1  write enable to register file (registered)
write_reg  output  ADDR_W  register file write index (registered)
writeData  output  DATA_W  register file write data (registered)
conflict_cnt  output  CNT_W  count of contended cycles, saturating

Behaviour:
- Reset (async, rst_n=0):
  - REGWRITE=0, write_reg=0, writeData=0, conflict_cnt=0.
  - last_grant=B, so A wins the first contention.
  - Outputs clear immediately, not on the next edge.
- Handshake:
  - Transfer occurs when valid&&ready are both high at a rising edge.
  - Requester holds reg/data stable while valid&&!ready.
  - ready is combinational from valid, reg, stall and last_grant; ready never depends on itself.
- stall=1: a_ready=b_ready=0. No grant, no counter update. REGWRITE goes to 0 on the next edge.
- Zero-register requests (reg==ZERO_REG, stall=0):
  - ready=1 unconditionally, including when the other requester is also valid.
  - Never drives REGWRITE and never changes last_grant.
- Real requests (reg!=ZERO_REG, stall=0):
  - Only A real: a_ready=1.
  - Only B real: b_ready=1.
  - Both real: grant the requester not equal to last_grant; the loser's ready=0.
- On a real grant at edge N:
  - Cycle N+1 shows REGWRITE=1, write_reg=granted reg, writeData=granted data.
  - last_grant updates to the winner.
  - Latency is exactly 1 cycle.
- No real grant at edge N: REGWRITE=0 in cycle N+1. write_reg/writeData hold their previous values.
- Throughput: one real write per cycle. Back-to-back grants keep REGWRITE high continuously.
- Same destination from both requesters: no merging. Each is written in grant order on consecutive cycles; the later grant's value persists.
- conflict_cnt increments by 1 on each edge where stall=0 and both requesters are valid real requests. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-transfer: an in-flight REGWRITE pulse is killed. Unaccepted requests are re-arbitrated after release, starting with A.

Test Plan:
1. Reset → check REGWRITE=0, conflict_cnt=0. Release reset; a_valid=1, a_reg=2, a_data=99999, b_valid=0 → a_ready=1 same cycle; next cycle REGWRITE=1, write_reg=2, writeData=99999; following cycle REGWRITE=0.
2. Both valid: a_reg=3/a_data=11, b_reg=4/b_data=22, held for 2 cycles → A granted first, then B. Output shows (3,11) then (4,22). conflict_cnt=1 (second cycle is uncontended).
3. Both valid and real for 4 cycles, each re-presenting a new request after acceptance → grants alternate A,B,A,B; REGWRITE stays high 4 cycles; conflict_cnt=4.
4. a_reg=31, b_reg=5/b_data=7, both valid → a_ready=1 and b_ready=1 same cycle; next cycle REGWRITE=1, write_reg=5, writeData=7. Also a_reg=31 alone → REGWRITE stays 0.
5. stall=1 with a_valid=1 for 3 cycles → a_ready=0, REGWRITE=0. Drop stall → grant next edge, REGWRITE=1 one cycle later.
6. Force conflict_cnt near max with CNT_W=2: 5 contended cycles → count reads 3 and holds. Pulse rst_n low during REGWRITE=1 → REGWRITE drops immediately, conflict_cnt=0.
